// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: PC, credit-limited imem requests, in-order response FIFO to decode.
// Optional misaligned-redirect trap enabled by defining IF_MISALIGN_TRAP_EN.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        fetch_fault
);

    localparam int          AW      = $clog2(DEPTH);
    localparam int          CW      = $clog2(DEPTH + 1);
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);
    localparam logic [31:0] NOP     = 32'h0000_0013;

    logic [31:0]   pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] outstanding_nxt;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] fifo_cnt;
    logic [CW:0]   in_use;

    logic [31:0]   pcq [DEPTH];
    logic [AW-1:0] pcq_wr;
    logic [AW-1:0] pcq_rd;

    logic [31:0]   fifo_instr [DEPTH];
    logic [31:0]   fifo_pc    [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    logic          fault_halt;
    logic [31:0]   target;
    logic          hs;
    logic          rsp;
    logic          dropping;
    logic          push;
    logic          pop;

`ifdef IF_MISALIGN_TRAP_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fault_halt <= 1'b0;
        end else if (redirect_valid) begin
            fault_halt <= (redirect_pc[1:0] != 2'b00);
        end
    end

    assign target      = redirect_pc;
    assign fetch_fault = fault_halt;
`else
    logic unused_lsbs;
    assign unused_lsbs = ^redirect_pc[1:0];
    assign fault_halt  = 1'b0;
    assign target      = {redirect_pc[31:2], 2'b00};
    assign fetch_fault = 1'b0;
`endif

    // Credit counts both buffered words and words still owed by memory.
    assign in_use    = {1'b0, fifo_cnt} + {1'b0, outstanding};
    assign imem_req  = !rst && !redirect_valid && (in_use < DEPTH_W) && !fault_halt;
    assign imem_addr = pc;

    assign hs       = imem_req && imem_gnt;
    assign rsp      = imem_rvalid && (outstanding != '0);
    assign dropping = rsp && (drop_cnt != '0);
    assign push     = rsp && !dropping && !redirect_valid;
    assign pop      = out_valid && out_ready;

    assign out_valid = (fifo_cnt != '0);
    assign out_instr = fifo_instr[rd_ptr];
    assign out_pc    = fifo_pc[rd_ptr];

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        outstanding_nxt = outstanding;
        if (hs && !rsp) begin
            outstanding_nxt = outstanding + 1'b1;
        end else if (!hs && rsp) begin
            outstanding_nxt = outstanding - 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc          <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
            pcq_wr      <= '0;
            pcq_rd      <= '0;
        end else begin
            outstanding <= outstanding_nxt;
            if (hs) begin
                pcq_wr <= pcq_wr + 1'b1;
            end
            if (rsp) begin
                pcq_rd <= pcq_rd + 1'b1;
            end
            if (redirect_valid) begin
                pc       <= target;
                drop_cnt <= outstanding_nxt;
            end else begin
                if (hs) begin
                    pc <= pc + 32'd4;
                end
                if (dropping) begin
                    drop_cnt <= drop_cnt - 1'b1;
                end
            end
        end
    end

    // NOTE: the request-PC queue has no reset; an entry is always written before it is read.
    always_ff @(posedge clk) begin
        if (hs) begin
            pcq[pcq_wr] <= pc;
        end
    end

    // Response FIFO; storage resets so decode sees a NOP at RESET_PC out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_instr[i] <= NOP;
                fifo_pc[i]    <= RESET_PC;
            end
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else if (redirect_valid) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) begin
                fifo_instr[wr_ptr] <= imem_rdata;
                fifo_pc[wr_ptr]    <= pcq[pcq_rd];
                wr_ptr             <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                fifo_cnt <= fifo_cnt + 1'b1;
            end else if (!push && pop) begin
                fifo_cnt <= fifo_cnt - 1'b1;
            end
        end
    end

endmodule
